wb_arbiter2: RTL and testbench

Two-master, one-slave arbiter for the pipelined 32-bit Wishbone bus used by the peripheral interfaces (LED, and later timers/UART). Grants the slave to one master for the full duration of its `cyc`, round-robin on contention, tracks outstanding requests, and terminates hung transactions with a bus error after a programmable timeout. It sits between the CPU data port / debug master and a peripheral slave port.

---
 rtl/wb_arbiter2.sv | 152 +++++++++++++++
 tb/tb_wb_arbiter2.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master / one-slave arbiter for the pipelined Wishbone bus.
// A master owns the slave for the whole of its cyc; ties go round-robin. Outstanding
// requests are counted (0..15) and a hung transaction is terminated with a one-cycle
// bus error after TimeoutCycles cycles without a response.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   mN_bus_cyc/stb/we/addr/      master N request (N = 0, 1)
//   mN_bus_data_m/sel
//   mN_bus_data_s/ack/stall/err  responses to master N
//   s_bus_cyc/stb/we/addr/       request to slave
//   s_bus_data_m/sel
//   s_bus_data_s/ack/stall/err   slave responses
module wb_arbiter2 #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned TimeoutCycles = 255,
  localparam int unsigned SelWidth     = DataWidth / 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  // master 0
  input  logic                 m0_bus_cyc,
  input  logic                 m0_bus_stb,
  input  logic                 m0_bus_we,
  input  logic [AddrWidth-1:0] m0_bus_addr,
  input  logic [DataWidth-1:0] m0_bus_data_m,
  input  logic [SelWidth-1:0]  m0_bus_sel,
  output logic [DataWidth-1:0] m0_bus_data_s,
  output logic                 m0_bus_ack,
  output logic                 m0_bus_stall,
  output logic                 m0_bus_err,
  // master 1
  input  logic                 m1_bus_cyc,
  input  logic                 m1_bus_stb,
  input  logic                 m1_bus_we,
  input  logic [AddrWidth-1:0] m1_bus_addr,
  input  logic [DataWidth-1:0] m1_bus_data_m,
  input  logic [SelWidth-1:0]  m1_bus_sel,
  output logic [DataWidth-1:0] m1_bus_data_s,
  output logic                 m1_bus_ack,
  output logic                 m1_bus_stall,
  output logic                 m1_bus_err,
  // slave
  output logic                 s_bus_cyc,
  output logic                 s_bus_stb,
  output logic                 s_bus_we,
  output logic [AddrWidth-1:0] s_bus_addr,
  output logic [DataWidth-1:0] s_bus_data_m,
  output logic [SelWidth-1:0]  s_bus_sel,
  input  logic [DataWidth-1:0] s_bus_data_s,
  input  logic                 s_bus_ack,
  input  logic                 s_bus_stall,
  input  logic                 s_bus_err
);

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

  localparam logic [7:0] TimerLast = 8'(TimeoutCycles - 1);

  state_e     r_state, w_state_next;
  logic       r_last, w_last_next;
  logic [3:0] r_outstanding, w_outstanding_next;
  logic [7:0] r_timer, w_timer_next;

  logic                 w_g0, w_g1, w_granted;
  logic                 w_m_cyc, w_m_stb, w_m_we;
  logic [AddrWidth-1:0] w_m_addr;
  logic [DataWidth-1:0] w_m_data;
  logic [SelWidth-1:0]  w_m_sel;
  logic                 w_full, w_resp, w_timeout, w_accept, w_dec, w_release;

  assign w_g0      = (r_state == StGrant0);
  assign w_g1      = (r_state == StGrant1);
  assign w_granted = w_g0 | w_g1;

  // Request from whichever master currently owns the bus.
  assign w_m_cyc  = w_g1 ? m1_bus_cyc    : m0_bus_cyc;
  assign w_m_stb  = w_g1 ? m1_bus_stb    : m0_bus_stb;
  assign w_m_we   = w_g1 ? m1_bus_we     : m0_bus_we;
  assign w_m_addr = w_g1 ? m1_bus_addr   : m0_bus_addr;
  assign w_m_data = w_g1 ? m1_bus_data_m : m0_bus_data_m;
  assign w_m_sel  = w_g1 ? m1_bus_sel    : m0_bus_sel;

  assign w_full    = (r_outstanding == 4'd15);
  assign w_resp    = s_bus_ack | s_bus_err;
  assign w_timeout = w_granted & (r_timer == TimerLast) & (r_outstanding != '0) & ~w_resp;
  assign w_accept  = s_bus_stb & ~s_bus_stall;
  // Responses with nothing outstanding must not underflow the counter.
  assign w_dec     = w_resp & (r_outstanding != '0);
  assign w_release = w_granted & (~w_m_cyc | w_timeout);

  // Slave side: zeroed while idle; cyc/stb dropped on the timeout cycle.
  assign s_bus_cyc    = w_granted & w_m_cyc & ~w_timeout;
  assign s_bus_stb    = w_granted & w_m_stb & ~w_full & ~w_timeout;
  assign s_bus_we     = w_granted & w_m_we;
  assign s_bus_addr   = w_granted ? w_m_addr : '0;
  assign s_bus_data_m = w_granted ? w_m_data : '0;
  assign s_bus_sel    = w_granted ? w_m_sel  : '0;

  // Master side: only the owner sees responses; everyone else is stalled.
  assign m0_bus_data_s = s_bus_data_s;
  assign m1_bus_data_s = s_bus_data_s;
  assign m0_bus_stall  = w_g0 ? (s_bus_stall | w_full) : 1'b1;
  assign m1_bus_stall  = w_g1 ? (s_bus_stall | w_full) : 1'b1;
  assign m0_bus_ack    = w_g0 & s_bus_ack;
  assign m1_bus_ack    = w_g1 & s_bus_ack;
  assign m0_bus_err    = w_g0 & (s_bus_err | w_timeout);
  assign m1_bus_err    = w_g1 & (s_bus_err | w_timeout);

  always_comb begin
    w_state_next       = r_state;
    w_last_next        = r_last;
    w_outstanding_next = r_outstanding + {3'b000, w_accept} - {3'b000, w_dec};
    w_timer_next       = ((r_outstanding == '0) | w_resp) ? 8'd0 : r_timer + 8'd1;
    unique case (r_state)
      StIdle: begin
        if (m0_bus_cyc && m1_bus_cyc) begin
          w_state_next = r_last ? StGrant0 : StGrant1;
        end else if (m0_bus_cyc) begin
          w_state_next = StGrant0;
        end else if (m1_bus_cyc) begin
          w_state_next = StGrant1;
        end
      end
      StGrant0, StGrant1: begin
        if (w_release) begin
          w_state_next       = StIdle;
          w_last_next        = w_g1;
          w_outstanding_next = 4'd0;
          w_timer_next       = 8'd0;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= StIdle;
      r_last        <= 1'b1;
      r_outstanding <= 4'd0;
      r_timer       <= 8'd0;
    end else begin
      r_state       <= w_state_next;
      r_last        <= w_last_next;
      r_outstanding <= w_outstanding_next;
      r_timer       <= w_timer_next;
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
module tb_wb_arbiter2;
  localparam int unsigned TO = 8;
  localparam int Cycles = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        m_cyc [2], m_stb [2], m_we [2];
  logic [31:0] m_addr [2], m_data [2];
  logic [3:0]  m_sel [2];
  logic [31:0] m0_data_s, m1_data_s;
  logic        m0_ack, m0_stall, m0_err, m1_ack, m1_stall, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_addr, s_data_m, s_data_s;
  logic [3:0]  s_sel;
  logic        s_ack, s_stall, s_err;

  wb_arbiter2 #(.DataWidth(32), .AddrWidth(32), .TimeoutCycles(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_bus_cyc(m_cyc[0]), .m0_bus_stb(m_stb[0]), .m0_bus_we(m_we[0]),
    .m0_bus_addr(m_addr[0]), .m0_bus_data_m(m_data[0]), .m0_bus_sel(m_sel[0]),
    .m0_bus_data_s(m0_data_s), .m0_bus_ack(m0_ack), .m0_bus_stall(m0_stall),
    .m0_bus_err(m0_err),
    .m1_bus_cyc(m_cyc[1]), .m1_bus_stb(m_stb[1]), .m1_bus_we(m_we[1]),
    .m1_bus_addr(m_addr[1]), .m1_bus_data_m(m_data[1]), .m1_bus_sel(m_sel[1]),
    .m1_bus_data_s(m1_data_s), .m1_bus_ack(m1_ack), .m1_bus_stall(m1_stall),
    .m1_bus_err(m1_err),
    .s_bus_cyc(s_cyc), .s_bus_stb(s_stb), .s_bus_we(s_we), .s_bus_addr(s_addr),
    .s_bus_data_m(s_data_m), .s_bus_sel(s_sel), .s_bus_data_s(s_data_s),
    .s_bus_ack(s_ack), .s_bus_stall(s_stall), .s_bus_err(s_err)
  );

  typedef struct packed {
    logic        cyc, stb, we;
    logic [31:0] addr, data;
    logic [3:0]  sel;
  } slv_t;
  typedef struct packed {
    logic [31:0] d0, d1;
    logic        ack0, stall0, err0, ack1, stall1, err1;
  } mst_t;
  typedef struct packed {
    slv_t s;
    mst_t m;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail = 0;

  // Reference model: bus owner (-1 = nobody), last served, pending count, idle wait.
  int owner, last, pend, waitc;

  // Stimulus profiles: general traffic, fill-to-full, hang-until-timeout.
  int ack_pct [3]  = '{40, 20, 0};
  int err_pct [3]  = '{5, 0, 0};
  int stl_pct [3]  = '{30, 0, 20};
  int stb_pct [3]  = '{60, 100, 50};
  int drop_pct [3] = '{10, 1, 1};

  function automatic bit chance(int pct);
    return $urandom_range(99) < pct;
  endfunction

  // Expected outputs for the current inputs, then advance the model one clock.
  task automatic model_step();
    exp_t e;
    bit   full, resp, to, acc;
    e = '0;
    e.m.d0 = s_data_s;
    e.m.d1 = s_data_s;
    e.m.stall0 = 1'b1;
    e.m.stall1 = 1'b1;
    full = (pend == 15);
    resp = s_ack || s_err;
    to   = (owner >= 0) && (waitc == TO - 1) && (pend > 0) && !resp;
    acc  = 1'b0;
    if (owner >= 0) begin
      e.s.cyc  = m_cyc[owner] && !to;
      e.s.stb  = m_stb[owner] && !full && !to;
      e.s.we   = m_we[owner];
      e.s.addr = m_addr[owner];
      e.s.data = m_data[owner];
      e.s.sel  = m_sel[owner];
      acc = e.s.stb && !s_stall;
      if (owner == 0) begin
        e.m.stall0 = s_stall || full;
        e.m.ack0   = s_ack;
        e.m.err0   = s_err || to;
      end else begin
        e.m.stall1 = s_stall || full;
        e.m.ack1   = s_ack;
        e.m.err1   = s_err || to;
      end
    end
    q.push_back(e);

    if (!reset_n) begin
      owner = -1; last = 1; pend = 0; waitc = 0;
    end else if (owner < 0) begin
      if (m_cyc[0] && m_cyc[1]) owner = 1 - last;
      else if (m_cyc[0])        owner = 0;
      else if (m_cyc[1])        owner = 1;
    end else if (!m_cyc[owner] || to) begin
      last = owner; owner = -1; pend = 0; waitc = 0;
    end else begin
      waitc = (pend == 0 || resp) ? 0 : waitc + 1;
      pend  = pend + (acc ? 1 : 0) - ((resp && pend > 0) ? 1 : 0);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare each against the queue.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      slv_t as;
      mst_t am;
      e  = q.pop_front();
      as = '{s_cyc, s_stb, s_we, s_addr, s_data_m, s_sel};
      am = '{m0_data_s, m1_data_s, m0_ack, m0_stall, m0_err, m1_ack, m1_stall, m1_err};
      n_tests++;
      if (as !== e.s) begin
        n_fail++;
        $display("FAIL slave_side t=%0t got=%h want=%h", $time, as, e.s);
      end
      n_tests++;
      if (am !== e.m) begin
        n_fail++;
        $display("FAIL master_side t=%0t got=%h want=%h", $time, am, e.m);
      end
    end
  end

  initial begin
    int ph;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
      m_addr[i] = '0; m_data[i] = '0; m_sel[i] = '0;
    end
    s_data_s = '0; s_ack = 1'b0; s_stall = 1'b0; s_err = 1'b0;
    repeat (2) @(posedge clk);
    owner = -1; last = 1; pend = 0; waitc = 0;

    for (int c = 0; c < Cycles; c++) begin
      @(posedge clk);
      #1;
      ph = (c / 200) % 3;
      reset_n = (c == 0) ? 1'b1 : !chance(1);
      for (int i = 0; i < 2; i++) begin
        if (m_cyc[i]) m_cyc[i] = !chance(drop_pct[ph]);
        else          m_cyc[i] = chance(30);
        m_stb[i]  = m_cyc[i] && chance(stb_pct[ph]);
        m_we[i]   = chance(50);
        m_addr[i] = $urandom;
        m_data[i] = $urandom;
        m_sel[i]  = 4'($urandom_range(15));
      end
      s_data_s = $urandom;
      s_ack    = chance(ack_pct[ph]);
      s_err    = !s_ack && chance(err_pct[ph]);
      s_stall  = chance(stl_pct[ph]);
      model_step();
    end

    repeat (2) @(posedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
